// File: rtl/printf_pipe_splitter.sv
// printf_pipe_splitter
//   Sink side of the 128-bit indication pipe. Messages tagged PRINTF_TAG in
//   word0[31:16] are captured and streamed as 32-bit words on the trace port.
//   Every other message passes straight through to the host pipe.
//   Optional build macro: PRINTF_SPLIT_TIMESTAMP_EN. When it is defined, a
//   free-running cycle counter is latched at capture and the stream carries
//   a timestamp word after word0.
module printf_pipe_splitter #(
  parameter logic [15:0] PRINTF_TAG = 16'h7FFF,
  parameter int          MAX_WORDS  = 4,
  parameter int          ERR_WIDTH  = 16
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 in_enq_ena,
  input  logic [127:0]         in_enq_v,
  output logic                 in_enq_rdy,
  output logic                 out_enq_ena,
  output logic [127:0]         out_enq_v,
  input  logic                 out_enq_rdy,
  output logic                 trace_enq_ena,
  output logic [31:0]          trace_enq_v,
  input  logic                 trace_enq_rdy,
  output logic                 busy,
  output logic [ERR_WIDTH-1:0] err_count
);

  localparam logic [2:0] MAX_LEN = 3'(MAX_WORDS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [127:0]          hold_q, hold_d;
  logic [2:0]            idx_q, idx_d;
  logic [2:0]            len_q, len_d;
  logic [ERR_WIDTH-1:0]  err_q, err_d;
  logic                  is_printf_s;
  logic                  capture_s;
  logic [2:0]            last_idx_s;
`ifdef PRINTF_SPLIT_TIMESTAMP_EN
  logic [31:0]           cyc_q;
  logic [31:0]           ts_q, ts_d;
  logic [2:0]            idx_m1_s;
`endif

  // Length field to word count: zero becomes one word, oversize is cut to MAX_LEN.
  function automatic logic [2:0] clamp_len(input logic [15:0] raw);
    logic [2:0] len;
    if (raw == 16'd0) begin
      len = 3'd1;
    end else if (raw > 16'(MAX_WORDS)) begin
      len = MAX_LEN;
    end else begin
      len = raw[2:0];
    end
    return len;
  endfunction

  // True when the length field had to be altered by clamp_len.
  function automatic logic len_is_bad(input logic [15:0] raw);
    return (raw == 16'd0) || (raw > 16'(MAX_WORDS));
  endfunction

  assign is_printf_s   = (in_enq_v[31:16] == PRINTF_TAG);
  assign capture_s     = in_enq_ena & is_printf_s & (state_q == ST_IDLE);
  assign busy          = (state_q == ST_SEND);
  assign in_enq_rdy    = ~busy & out_enq_rdy;
  assign out_enq_ena   = in_enq_ena & ~is_printf_s;
  assign out_enq_v     = in_enq_v;
  assign trace_enq_ena = busy & trace_enq_rdy;
  assign err_count     = err_q;

`ifdef PRINTF_SPLIT_TIMESTAMP_EN
  // The timestamp word stretches the stream by one, so the last index is len.
  assign last_idx_s = len_q;
  assign idx_m1_s   = idx_q - 3'd1;

  // Trace word select: rewritten header, timestamp, then payload words 1..len-1.
  always_comb begin
    trace_enq_v = 32'd0;
    case (idx_q)
      3'd0:    trace_enq_v = {hold_q[31:16], 16'(len_q) + 16'd1};
      3'd1:    trace_enq_v = ts_q;
      default: trace_enq_v = hold_q[{idx_m1_s[1:0], 5'd0} +: 32];
    endcase
  end

  // Free-running cycle counter; wraps naturally at 2^32.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cyc_q <= 32'd0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
    end
  end
`else
  assign last_idx_s = len_q - 3'd1;

  // Trace word select: the idx-th 32-bit word of the held message.
  always_comb begin
    trace_enq_v = hold_q[{idx_q[1:0], 5'd0} +: 32];
  end
`endif

  // Next-state logic: capture in IDLE, advance one word per accepted trace beat.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    len_d   = len_q;
    err_d   = err_q;
`ifdef PRINTF_SPLIT_TIMESTAMP_EN
    ts_d    = ts_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (capture_s) begin
          state_d = ST_SEND;
          hold_d  = in_enq_v;
          idx_d   = 3'd0;
          len_d   = clamp_len(in_enq_v[15:0]);
`ifdef PRINTF_SPLIT_TIMESTAMP_EN
          ts_d    = cyc_q;
`endif
          if (len_is_bad(in_enq_v[15:0]) && (err_q != {ERR_WIDTH{1'b1}})) begin
            err_d = err_q + ERR_WIDTH'(1);
          end else begin
            err_d = err_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (trace_enq_rdy) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == last_idx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset drops any message in flight.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      hold_q  <= 128'd0;
      idx_q   <= 3'd0;
      len_q   <= 3'd0;
      err_q   <= {ERR_WIDTH{1'b0}};
`ifdef PRINTF_SPLIT_TIMESTAMP_EN
      ts_q    <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      err_q   <= err_d;
`ifdef PRINTF_SPLIT_TIMESTAMP_EN
      ts_q    <= ts_d;
`endif
    end
  end

endmodule

// File: tb/tb_printf_pipe_splitter.sv
// Self-checking bench for printf_pipe_splitter: a queue-based model of the
// expected trace stream, directed scenarios with literal values, then
// randomized traffic. A second instance with a 4-bit error counter exercises
// saturation in a reasonable number of cycles.
module tb_printf_pipe_splitter;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         in_ena;
  logic [127:0] in_v;
  logic         out_rdy;
  logic         trace_rdy;
  logic         in_rdy_o, out_ena_o, trace_ena_o, busy_o;
  logic [127:0] out_v_o;
  logic [31:0]  trace_v_o;
  logic [15:0]  err_o;
  logic         sat_in_rdy, sat_out_ena, sat_trace_ena, sat_busy;
  logic [127:0] sat_out_v;
  logic [31:0]  sat_trace_v;
  logic [3:0]   sat_err;

  always #5 CLK = ~CLK;

  printf_pipe_splitter dut (
    .CLK(CLK), .nRST(nRST),
    .in_enq_ena(in_ena), .in_enq_v(in_v), .in_enq_rdy(in_rdy_o),
    .out_enq_ena(out_ena_o), .out_enq_v(out_v_o), .out_enq_rdy(out_rdy),
    .trace_enq_ena(trace_ena_o), .trace_enq_v(trace_v_o), .trace_enq_rdy(trace_rdy),
    .busy(busy_o), .err_count(err_o)
  );

  printf_pipe_splitter #(.ERR_WIDTH(4)) dut_sat (
    .CLK(CLK), .nRST(nRST),
    .in_enq_ena(in_ena), .in_enq_v(in_v), .in_enq_rdy(sat_in_rdy),
    .out_enq_ena(sat_out_ena), .out_enq_v(sat_out_v), .out_enq_rdy(out_rdy),
    .trace_enq_ena(sat_trace_ena), .trace_enq_v(sat_trace_v), .trace_enq_rdy(trace_rdy),
    .busy(sat_busy), .err_count(sat_err)
  );

  // Behavioural model: the words still owed on the trace port, and counters.
  logic [31:0] exp_q[$];
  int          m_err = 0;
  logic [31:0] m_cnt = 32'd0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  // Values sampled in the most recent step, for literal checks.
  logic        s_in_rdy, s_out_ena, s_trace_ena, s_busy;
  logic [31:0] s_trace_v;
  logic [15:0] s_err;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic model_busy();
    return exp_q.size() != 0;
  endfunction

  // Build the expected word stream for a captured printf message.
  task automatic model_capture(input logic [127:0] v);
    int raw, len;
    raw = int'(v[15:0]);
    if (raw == 0) len = 1;
    else if (raw > 4) len = 4;
    else len = raw;
    if (raw == 0 || raw > 4) m_err = (m_err < 65535) ? m_err + 1 : 65535;
`ifdef PRINTF_SPLIT_TIMESTAMP_EN
    exp_q.push_back({v[31:16], 16'(len + 1)});
    exp_q.push_back(m_cnt);
    for (int k = 1; k < len; k++) exp_q.push_back(v[32*k +: 32]);
`else
    for (int k = 0; k < len; k++) exp_q.push_back(v[32*k +: 32]);
`endif
  endtask

  // One clock cycle: drive at negedge, compare all outputs against the model, advance model.
  task automatic step(input logic rst_n, input logic ena, input logic [127:0] v,
                      input logic ordy, input logic trdy);
    logic mb, is_p;
    @(negedge CLK);
    nRST = rst_n; in_ena = ena; in_v = v; out_rdy = ordy; trace_rdy = trdy;
    #1;
    mb   = model_busy();
    is_p = (v[31:16] == 16'h7FFF);
    check("in_rdy", 128'(in_rdy_o), 128'(!mb && ordy));
    check("out_ena", 128'(out_ena_o), 128'(ena && !is_p));
    if (ena && !is_p) check("out_v", out_v_o, v);
    check("trace_ena", 128'(trace_ena_o), 128'(mb && trdy));
    if (mb && trdy) check("trace_v", 128'(trace_v_o), 128'(exp_q[0]));
    check("busy", 128'(busy_o), 128'(mb));
    check("err_count", 128'(err_o), 128'(m_err));
    check("sat_err", 128'(sat_err), 128'((m_err > 15) ? 15 : m_err));
    s_in_rdy = in_rdy_o; s_out_ena = out_ena_o; s_trace_ena = trace_ena_o;
    s_busy = busy_o; s_trace_v = trace_v_o; s_err = err_o;
    if (!rst_n) begin
      exp_q.delete();
      m_err = 0;
      m_cnt = 32'd0;
    end else begin
      if (mb && trdy) void'(exp_q.pop_front());
      else if (!mb && ena && is_p && ordy) model_capture(v);
      m_cnt = m_cnt + 32'd1;
    end
  endtask

  task automatic idle(input logic trdy);
    step(1'b1, 1'b0, 128'd0, 1'b1, trdy);
  endtask

  // Drain with trace always ready, returning how many words appeared (bounded).
  task automatic drain_count(output int n);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      idle(1'b1);
      if (s_trace_ena) n++;
      else break;
    end
  endtask

  logic [127:0] msg2, pv;
  int nw;

  initial begin
    msg2 = {32'h0, 32'h5, 32'h9, 32'h7FFF_0003};
    nRST = 1'b0; in_ena = 1'b0; in_v = 128'd0; out_rdy = 1'b1; trace_rdy = 1'b1;
    repeat (2) @(posedge CLK);

    // Pass-through of a non-printf message.
    pv = {32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D, 32'h0003_0002};
    step(1'b1, 1'b1, pv, 1'b1, 1'b1);
    check("t1_out_ena", 128'(s_out_ena), 128'd1);
    check("t1_trace_idle", 128'(s_trace_ena), 128'd0);

`ifndef PRINTF_SPLIT_TIMESTAMP_EN
    // Three-word printf with trace always ready.
    step(1'b1, 1'b1, msg2, 1'b1, 1'b1);
    idle(1'b1); check("t2_w0", 128'(s_trace_v), 128'h7FFF_0003); check("t2_rdy1", 128'(s_in_rdy), 128'd0);
    idle(1'b1); check("t2_w1", 128'(s_trace_v), 128'h0000_0009); check("t2_rdy2", 128'(s_in_rdy), 128'd0);
    idle(1'b1); check("t2_w2", 128'(s_trace_v), 128'h0000_0005); check("t2_rdy3", 128'(s_in_rdy), 128'd0);
    idle(1'b1); check("t2_rdy4", 128'(s_in_rdy), 128'd1); check("t2_done", 128'(s_trace_ena), 128'd0);

    // Same message with trace backpressure on T+2..T+4.
    step(1'b1, 1'b1, msg2, 1'b1, 1'b1);
    idle(1'b1); check("t3_w0", 128'(s_trace_v), 128'h7FFF_0003);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      check("t3_stall_ena", 128'(s_trace_ena), 128'd0);
      check("t3_stall_v", 128'(s_trace_v), 128'h0000_0009);
    end
    idle(1'b1); check("t3_w1", 128'(s_trace_v), 128'h0000_0009); check("t3_w1_ena", 128'(s_trace_ena), 128'd1);
    idle(1'b1); check("t3_w2", 128'(s_trace_v), 128'h0000_0005);
    idle(1'b1); check("t3_done", 128'(s_trace_ena), 128'd0);
`else
    // Timestamped printf captured when the counter reads 0x10.
    step(1'b0, 1'b0, 128'd0, 1'b1, 1'b1);
    repeat (16) idle(1'b1);
    step(1'b1, 1'b1, {32'h0, 32'h0, 32'hAAAA_BBBB, 32'h7FFF_0002}, 1'b1, 1'b1);
    idle(1'b1); check("t6_w0", 128'(s_trace_v), 128'h7FFF_0003);
    idle(1'b1); check("t6_ts", 128'(s_trace_v), 128'h0000_0010);
    idle(1'b1); check("t6_w1", 128'(s_trace_v), 128'hAAAA_BBBB);
    idle(1'b1); check("t6_done", 128'(s_trace_ena), 128'd0);
`endif

    // Host stall blocks input even while idle.
    step(1'b1, 1'b0, 128'd0, 1'b0, 1'b1);
    check("t5_host_stall", 128'(s_in_rdy), 128'd0);

    // Reset mid-message at idx=1 discards the rest.
    step(1'b1, 1'b1, msg2, 1'b1, 1'b1);
    idle(1'b1);
    step(1'b0, 1'b0, 128'd0, 1'b1, 1'b1);
    idle(1'b1); check("t5_rst_busy", 128'(s_busy), 128'd0); check("t5_rst_trace", 128'(s_trace_ena), 128'd0);
    idle(1'b1); check("t5_rst_trace2", 128'(s_trace_ena), 128'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic r, e, o, t;
      logic [127:0] v;
      r = ($urandom_range(0, 99) != 0);
      o = ($urandom_range(0, 9) < 8);
      t = ($urandom_range(0, 9) < 7);
      v = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 9) < 4) v[31:16] = 16'h7FFF;
      v[15:0] = 16'($urandom_range(0, 7));
      e = r && o && !model_busy() && ($urandom_range(0, 1) == 1);
      step(r, e, v, o, t);
    end

    // Length clamping and error-counter saturation.
    step(1'b0, 1'b0, 128'd0, 1'b1, 1'b1);
    step(1'b1, 1'b1, {96'h1, 32'h7FFF_0000}, 1'b1, 1'b1);
    drain_count(nw);
`ifdef PRINTF_SPLIT_TIMESTAMP_EN
    check("t4_len0_words", 128'(nw), 128'd2);
`else
    check("t4_len0_words", 128'(nw), 128'd1);
`endif
    step(1'b1, 1'b1, {96'h3_0000_0002_0000_0001, 32'h7FFF_0007}, 1'b1, 1'b1);
    drain_count(nw);
`ifdef PRINTF_SPLIT_TIMESTAMP_EN
    check("t4_len7_words", 128'(nw), 128'd5);
`else
    check("t4_len7_words", 128'(nw), 128'd4);
`endif
    check("t4_err2", 128'(s_err), 128'd2);
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 1'b1, {96'h0, 32'h7FFF_0000}, 1'b1, 1'b1);
      drain_count(nw);
    end
    check("t4_err20", 128'(err_o), 128'd20);
    check("t4_sat_err", 128'(sat_err), 128'hF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
